// File: rtl/gan_stream_pkg.sv
// Shared types and defaults for the GAN layer streaming stages.
package gan_stream_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } stream_state_t;

    localparam int GAN_DATA_W  = 16;
    localparam int GAN_N_ELEM  = 128;
    // Leaky slope of 1/4 for negative Q8.8 values
    localparam int LEAKY_SHIFT = 2;

endpackage

// File: rtl/layer_output_streamer_if.sv
// Valid/ready element stream carrying data, element index and last flag.
interface layer_output_streamer_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 7
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/leaky_relu_q8_8.sv
// Combinational leaky ReLU for signed Q8.8 values: negative inputs are
// scaled by 1/4 with an arithmetic shift, non-negative inputs pass as is.
module leaky_relu_q8_8
    import gan_stream_pkg::*;
#(
    parameter int DATA_W = GAN_DATA_W
) (
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y
);
    logic signed [DATA_W-1:0] shifted;

    assign shifted = $signed(x) >>> LEAKY_SHIFT;
    assign y       = x[DATA_W-1] ? $unsigned(shifted) : x;
endmodule

// File: rtl/layer_output_streamer.sv
// Snapshots a layer's flattened output on its done pulse and streams the
// elements one per beat over a valid/ready interface.
// Optional feature: define LAYER_STREAM_LEAKY_RELU_EN to apply a leaky
// ReLU to every emitted element; otherwise elements pass bit-exact.
module layer_output_streamer
    import gan_stream_pkg::*;
#(
    parameter int N_ELEM = GAN_N_ELEM,
    parameter int DATA_W = GAN_DATA_W,
    parameter int IDX_W  = $clog2(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     layer_done,
    input  logic [DATA_W*N_ELEM-1:0] layer_flat,
    layer_output_streamer_if.master  stream,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     overflow
);
    stream_state_t     state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              valid_reg, valid_next;
    logic              last_reg, last_next;
    logic              frame_done_reg, frame_done_next;
    logic              overflow_reg, overflow_next;

    logic [DATA_W-1:0] shadow_reg [N_ELEM];
    logic [DATA_W-1:0] flat_elem  [N_ELEM];

    logic              beat;
    logic              final_beat;
    logic              capture;
    logic [IDX_W-1:0]  idx_inc;
    logic [DATA_W-1:0] raw_elem;
    logic [DATA_W-1:0] act_elem;

    // Unpack the flattened bus into per-element words
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_unpack
            assign flat_elem[gi] = layer_flat[(gi+1)*DATA_W-1 -: DATA_W];
        end
    endgenerate

    assign beat       = valid_reg && stream.out_ready;
    assign final_beat = beat && last_reg;
    // A new frame is accepted when idle, or exactly as the last beat leaves
    assign capture    = layer_done && ((state_reg == ST_IDLE) || final_beat);
    assign idx_inc    = idx_reg + IDX_W'(1);
    // Element 0 of a fresh frame comes straight from the bus, since the
    // shadow copy is only written on this same edge
    assign raw_elem   = capture ? flat_elem[0] : shadow_reg[idx_inc];

`ifdef LAYER_STREAM_LEAKY_RELU_EN
    leaky_relu_q8_8 #(.DATA_W(DATA_W)) u_act (
        .x (raw_elem),
        .y (act_elem)
    );
`else
    assign act_elem = raw_elem;
`endif

    // Shadow register: full-frame snapshot, no reset needed
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N_ELEM; i++) begin
                shadow_reg[i] <= flat_elem[i];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            last_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            data_reg       <= data_next;
            valid_reg      <= valid_next;
            last_reg       <= last_next;
            frame_done_reg <= frame_done_next;
            overflow_reg   <= overflow_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        data_next       = data_reg;
        valid_next      = valid_reg;
        last_next       = last_reg;
        frame_done_next = 1'b0;
        overflow_next   = overflow_reg;

        case (state_reg)
            ST_IDLE: begin
                if (capture) begin
                    state_next = ST_STREAM;
                    idx_next   = '0;
                    data_next  = act_elem;
                    valid_next = 1'b1;
                    last_next  = (N_ELEM == 1);
                end
            end
            ST_STREAM: begin
                if (layer_done && !final_beat) begin
                    overflow_next = 1'b1;
                end
                if (beat) begin
                    if (last_reg) begin
                        frame_done_next = 1'b1;
                        if (capture) begin
                            idx_next   = '0;
                            data_next  = act_elem;
                            valid_next = 1'b1;
                            last_next  = (N_ELEM == 1);
                        end else begin
                            state_next = ST_IDLE;
                            valid_next = 1'b0;
                            last_next  = 1'b0;
                        end
                    end else begin
                        idx_next  = idx_inc;
                        data_next = act_elem;
                        last_next = (idx_inc == IDX_W'(N_ELEM - 1));
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign stream.out_valid = valid_reg;
    assign stream.out_data  = data_reg;
    assign stream.out_idx   = idx_reg;
    assign stream.out_last  = last_reg;
    assign frame_done       = frame_done_reg;
    assign busy             = (state_reg == ST_STREAM);
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_layer_output_streamer.sv
// Self-checking bench for layer_output_streamer: frame table plus
// hand-written overflow, back-to-back and mid-frame reset sequences.
module tb_layer_output_streamer;
    localparam int N  = 128;
    localparam int DW = 16;
    localparam int IW = 7;

`ifdef LAYER_STREAM_LEAKY_RELU_EN
    localparam bit ACT = 1'b1;
`else
    localparam bit ACT = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct {
        int            mode;   // 0 ready=1, 1 pattern 1001, 2 random
        logic [DW-1:0] e0, e1; // elements 0 and 1 driven
        logic [DW-1:0] x0, x1; // elements 0 and 1 expected
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            layer_done;
    logic [DW*N-1:0] layer_flat;
    logic            frame_done, busy, overflow;

    layer_output_streamer_if #(.DATA_W(DW), .IDX_W(IW)) sif ();

    layer_output_streamer #(.N_ELEM(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .layer_done (layer_done),
        .layer_flat (layer_flat),
        .stream     (sif.master),
        .frame_done (frame_done),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    beats, fd_cnt, first_cyc, last_cyc, fd_cyc;
    beat_t sb_q[$];
    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    vec_t  vecs[5];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW*N-1:0] make_flat(logic [DW-1:0] off, logic [DW-1:0] e0, logic [DW-1:0] e1);
        logic [DW*N-1:0] f;
        for (int i = 0; i < N; i++)
            f[i*DW +: DW] = (i == 0) ? e0 : (i == 1) ? e1 : DW'(i * 256) + off;
        return f;
    endfunction

    task automatic push_frame(logic [DW-1:0] off, logic [DW-1:0] x0, logic [DW-1:0] x1);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = (i == 0) ? x0 : (i == 1) ? x1 : DW'(i * 256) + off;
            b.idx  = IW'(i);
            b.last = (i == N - 1);
            sb_q.push_back(b);
        end
    endtask

    // Sampled on the falling edge, between the bench's input updates
    task automatic monitor();
        beat_t got, e;
        got = {sif.out_data, sif.out_idx, sif.out_last};
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (prev_stall)
            chk("stall_hold", 32'(got), 32'(prev_beat));
        if (sif.out_valid)
            chk("busy_while_valid", 32'(busy), 32'd1);
        if (sif.out_valid && sif.out_ready) begin
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                $display("beat idx=%0d data=%h last=%0d exp_data=%h", got.idx, got.data, got.last, e.data);
                chk("beat", 32'(got), 32'(e));
            end
        end
        prev_stall = sif.out_valid && !sif.out_ready;
        prev_beat  = got;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        sb_q.delete();
        prev_stall = 1'b0;
        step();
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_valid", 32'(sif.out_valid), 32'd0);
    endtask

    task automatic run_frame(int v, int ovf_at);
        int       k = 0;
        int       t0;
        bit       ovf_done = 1'b0;
        logic [3:0] pat = 4'b1001;
        layer_flat = make_flat(16'h0000, vecs[v].e0, vecs[v].e1);
        push_frame(16'h0000, vecs[v].x0, vecs[v].x1);
        beats  = 0;
        fd_cnt = 0;
        layer_done = 1'b1;
        sif.out_ready = 1'b1;
        t0 = cyc;
        step();
        layer_done = 1'b0;
        while (!(sb_q.size() == 0 && fd_cnt >= 1) && k < 1500) begin
            case (vecs[v].mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = pat[k % 4];
                default: sif.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (ovf_at >= 0 && !ovf_done && sif.out_valid && sif.out_idx == IW'(ovf_at)) begin
                layer_done = 1'b1;
                layer_flat = make_flat(16'h5555, 16'hAAAA, 16'hAAAA);
                ovf_done   = 1'b1;
            end
            step();
            layer_done = 1'b0;
            k++;
        end
        if (k >= 1500) chk("frame_timeout", 32'(k), 32'd0);
        sif.out_ready = 1'b1;
        step();
        step();
        $display("frame vec=%0d mode=%0d beats=%0d frame_done=%0d overflow=%0d", v, vecs[v].mode, beats, fd_cnt, overflow);
        chk("frame_beats", 32'(beats), 32'd128);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(sif.out_valid), 32'd0);
        if (vecs[v].mode == 0) begin
            chk("first_beat_cycle", 32'(first_cyc), 32'(t0 + 1));
            chk("last_beat_cycle", 32'(last_cyc), 32'(t0 + 128));
            chk("frame_done_cycle", 32'(fd_cyc), 32'(t0 + 129));
        end
        if (ovf_at >= 0) begin
            chk("overflow_set", 32'(overflow), 32'd1);
            repeat (4) step();
            chk("overflow_sticky", 32'(overflow), 32'd1);
        end else begin
            chk("overflow_clear", 32'(overflow), 32'd0);
        end
    endtask

    initial begin
        int  k;
        bit  b2b_done;
        rst = 1'b0;
        layer_done = 1'b0;
        layer_flat = '0;
        sif.out_ready = 1'b1;

        vecs[0] = '{0, 16'h0000, 16'h0100, 16'h0000, 16'h0100};
        vecs[1] = '{1, 16'h0000, 16'h0100, 16'h0000, 16'h0100};
        vecs[2] = '{0, 16'hFC00, 16'h0300, ACT ? 16'hFF00 : 16'hFC00, 16'h0300};
        vecs[3] = '{2, 16'h8000, 16'hFFFF, ACT ? 16'hE000 : 16'h8000, 16'hFFFF};
        vecs[4] = '{1, 16'h7FFF, 16'hFFFC, 16'h7FFF, ACT ? 16'hFFFF : 16'hFFFC};

        // Reset held with layer_done asserted: nothing may be captured
        layer_done = 1'b1;
        layer_flat = make_flat(16'h0000, 16'h1234, 16'h5678);
        repeat (3) step();
        rst = 1'b1;
        layer_done = 1'b0;
        step();
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_data", 32'(sif.out_data), 32'd0);
        chk("rst_idx", 32'(sif.out_idx), 32'd0);
        chk("rst_last", 32'(sif.out_last), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) step();
        chk("rst_no_capture", 32'({sif.out_valid, busy}), 32'd0);

        for (int v = 0; v < 5; v++) run_frame(v, -1);

        // Second done pulse mid-frame is dropped and flagged
        run_frame(0, 40);
        do_reset();

        // Back-to-back: next frame captured on the final beat of the first
        layer_flat = make_flat(16'h0000, 16'h0000, 16'h0100);
        push_frame(16'h0000, 16'h0000, 16'h0100);
        beats = 0;
        fd_cnt = 0;
        b2b_done = 1'b0;
        sif.out_ready = 1'b1;
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        k = 0;
        while (!(b2b_done && sb_q.size() == 0 && fd_cnt >= 2) && k < 1500) begin
            if (!b2b_done && sif.out_valid && sif.out_idx == IW'(N - 1)) begin
                layer_done = 1'b1;
                layer_flat = make_flat(16'h0080, 16'h0080, 16'h0180);
                push_frame(16'h0080, 16'h0080, 16'h0180);
                b2b_done = 1'b1;
                step();
                layer_done = 1'b0;
                $display("b2b boundary valid=%0d idx=%0d data=%h frame_done=%0d", sif.out_valid, sif.out_idx, sif.out_data, frame_done);
                chk("b2b_valid", 32'(sif.out_valid), 32'd1);
                chk("b2b_idx0", 32'(sif.out_idx), 32'd0);
                chk("b2b_data0", 32'(sif.out_data), 32'h0080);
                chk("b2b_frame_done", 32'(frame_done), 32'd1);
            end else begin
                step();
            end
            k++;
        end
        if (k >= 1500) chk("b2b_timeout", 32'(k), 32'd0);
        step();
        step();
        chk("b2b_beats", 32'(beats), 32'd256);
        chk("b2b_frame_done_count", 32'(fd_cnt), 32'd2);
        chk("b2b_overflow", 32'(overflow), 32'd0);

        // Reset mid-frame discards the frame without a frame_done
        layer_flat = make_flat(16'h0000, 16'h0000, 16'h0100);
        push_frame(16'h0000, 16'h0000, 16'h0100);
        fd_cnt = 0;
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        repeat (20) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb_q.delete();
        prev_stall = 1'b0;
        repeat (3) step();
        $display("midreset valid=%0d busy=%0d frame_done_count=%0d", sif.out_valid, busy, fd_cnt);
        chk("midrst_frame_done", 32'(fd_cnt), 32'd0);
        chk("midrst_valid", 32'(sif.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", 32'(sif.out_data), 32'd0);
        chk("midrst_idx", 32'(sif.out_idx), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
